stack_arbiter: RTL and testbench
================================

Name: stack_arbiter

Overview:
- Sequences and shares one on-chip LIFO store between two requesters.
- Each requester raises a push/pop request. The block arbitrates round-robin, executes one stack operation at a time, and returns a one-cycle done pulse with pop data and error status.
- Owns the pointer, full/empty flags and storage. Full is asserted at exactly DEPTH entries, so the last slot is usable.
- Sits between the user-facing control logic and the stack storage, and replaces direct per-client pointer handling.

Parameters:
- WIDTH, 4, data word width in bits.
- DEPTH, 16, number of stack entries; must be a power of two and at least 2.
- AW, $clog2(DEPTH), address width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  2  per-requester request; level, held until the matching done.
- op  input  2  per-requester operation, sampled with req: 1 = push, 0 = pop.
- wdata0  input  WIDTH  push data, requester 0.
- wdata1  input  WIDTH  push data, requester 1.
- done  output  2  one-cycle completion pulse, one-hot.
- rdata  output  WIDTH  pop result; valid only while done is nonzero.
- err  output  1  with done: push when full, or pop when empty.
- busy  output  1  state is not IDLE.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  AW+1  current occupancy.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; count = 0; done = 0; rdata = 0; err = 0; busy = 0; full = 0; empty = 1; rr_last = 1, so requester 0 wins the first tie.
  - Memory contents are not cleared.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
  - IDLE: if req != 0, latch winner, op[winner] and wdata[winner]; go to EXEC. Otherwise stay.
  - EXEC, push, not full: mem[count] <= wdata; count + 1.
  - EXEC, push, full: no write; set err flag.
  - EXEC, pop, not empty: rdata_r <= mem[count-1]; count - 1.
  - EXEC, pop, empty: rdata_r <= 0; set err flag.
  - EXEC always goes to RESP.
  - RESP: done[winner] = 1, rdata = rdata_r, err = err flag, all for exactly this cycle; rr_last <= winner; go to IDLE.
- Arbitration:
  - Single request: that requester wins.
  - Both requesting: the requester that did not win last wins.
- Latency: req sampled in IDLE at cycle N gives done at cycle N+2. Minimum spacing between operations is 3 cycles.
- Requester rules:
  - The requester must deassert req, or present a new op, in the cycle after done.
  - A req still high in the IDLE cycle after done is treated as a new request.
- Boundaries and corner cases:
  - Once latched in IDLE, the operation completes even if req drops during EXEC or RESP.
  - count never exceeds DEPTH and never underflows.
  - full/empty/count update on the clock edge ending EXEC and are visible during RESP.
  - Inputs change freely outside the IDLE sample point.
  - rdata and err are 0 whenever done == 0.
  - Reset asserted mid-operation aborts the operation: no done pulse, count = 0.

Optional Feature:
- Macro: STACK_ARBITER_WATERMARK_EN.
- When defined:
  - Adds parameter AF_LEVEL (default DEPTH-2) and output almost_full (1 bit).
  - almost_full = (count >= AF_LEVEL), registered alongside count; reset value 0.
- When undefined: the port and parameter are absent and the logic is otherwise identical.

Decomposition:
- Package stack_arbiter_pkg:
  - State enum: IDLE, EXEC, RESP.
  - Constants OP_POP = 1'b0 and OP_PUSH = 1'b1.
  - Requester count constant NREQ = 2.
- Sub-module stack_arbiter_rr: 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: gnt_valid, gnt_idx.
  - Purely combinational; the rr_last register lives in the parent.
- Storage is an internal register array; it is not a sub-module.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, done=0, busy=0.
- Req0 push 0xA, then req0 push 0x5, then req1 pop ->
  - done[0] pulses at N+2 for each push;
  - the pop returns rdata=0x5 with done[1]=1, err=0;
  - count goes 1, 2, 1.
- Both requesters push every opportunity after reset ->
  - grants alternate 0,1,0,1;
  - 16 pushes give full=1, count=16;
  - the 17th push gives done with err=1 and count stays 16.
- Pop from empty after reset -> done with err=1, rdata=0, count=0, empty stays 1.
- Push 0x3, then assert rst during EXEC of a second push ->
  - no done pulse;
  - count=0 and empty=1 immediately (async);
  - a subsequent pop gives err=1.
- With STACK_ARBITER_WATERMARK_EN and AF_LEVEL=14 -> almost_full rises when count reaches 14 and falls when a pop brings count to 13.

Source files
------------

// File: rtl/stack_arbiter_pkg.sv
// Shared types and constants for the two-requester LIFO arbiter.
// Includes the FSM state encoding, the op codes and the requester count.
package stack_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OP_POP  = 1'b0;
    localparam logic OP_PUSH = 1'b1;
    localparam int   NREQ    = 2;

endpackage

// File: rtl/stack_arbiter_rr.sv
// Two-way round-robin picker; purely combinational, the last-winner register lives in the parent.
module stack_arbiter_rr
    import stack_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic            last,
    output logic            gnt_valid,
    output logic            gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        if (req == 2'b11) begin
            gnt_idx = ~last;
        end else if (req[1]) begin
            gnt_idx = 1'b1;
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Shared LIFO store with round-robin access for two requesters: IDLE -> EXEC -> RESP.
// Optional almost-full watermark output enabled by STACK_ARBITER_WATERMARK_EN.
module stack_arbiter
    import stack_arbiter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
`ifdef STACK_ARBITER_WATERMARK_EN
    ,
    parameter int AF_LEVEL = DEPTH - 2
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  op,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic [NREQ-1:0]  done,
    output logic [WIDTH-1:0] rdata,
    output logic             err,
    output logic             busy,
    output logic             full,
    output logic             empty,
`ifdef STACK_ARBITER_WATERMARK_EN
    output logic             almost_full,
`endif
    output logic [AW:0]      count
);

    localparam logic [AW:0] L_FULL = (AW + 1)'(DEPTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_win;
    logic             r_op;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_rdata;
    logic             r_err;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_nxt;
    logic [AW:0]      w_count_m1;
    logic             r_rr_last;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_gnt_valid;
    logic             w_gnt_idx;
    logic             w_full;
    logic             w_empty;
    logic             w_take;

    stack_arbiter_rr u_rr (
        .req       (req),
        .last      (r_rr_last),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    assign w_full     = (r_count == L_FULL);
    assign w_empty    = (r_count == '0);
    assign w_count_m1 = r_count - 1'b1;
    assign w_take     = (r_state == IDLE) && w_gnt_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            IDLE: if (w_gnt_valid) w_state_nxt = EXEC;
            EXEC: begin
                w_state_nxt = RESP;
                if (r_op == OP_PUSH && !w_full) begin
                    w_count_nxt = r_count + 1'b1;
                end else if (r_op == OP_POP && !w_empty) begin
                    w_count_nxt = w_count_m1;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win     <= 1'b0;
            r_op      <= OP_POP;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_count   <= '0;
            r_rr_last <= 1'b1;
        end else begin
            r_count <= w_count_nxt;
            if (w_take) begin
                r_win <= w_gnt_idx;
                r_op  <= op[w_gnt_idx];
                r_err <= 1'b0;
            end
            if (r_state == EXEC) begin
                r_rdata <= '0;
                if (r_op == OP_PUSH) begin
                    r_err <= w_full;
                end else begin
                    r_err <= w_empty;
                    if (!w_empty) r_rdata <= r_mem[w_count_m1[AW-1:0]];
                end
            end
            if (r_state == RESP) begin
                r_rr_last <= r_win;
            end
        end
    end

    // Datapath registers carry no reset; contents are only consumed after a latch.
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_wdata <= w_gnt_idx ? wdata1 : wdata0;
        end
        if (r_state == EXEC && r_op == OP_PUSH && !w_full) begin
            r_mem[r_count[AW-1:0]] <= r_wdata;
        end
    end

`ifdef STACK_ARBITER_WATERMARK_EN
    localparam logic [AW:0] L_AF = (AW + 1)'(AF_LEVEL);
    logic r_almost_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (w_count_nxt >= L_AF);
        end
    end

    assign almost_full = r_almost_full;
`endif

    assign done  = (r_state == RESP) ? (r_win ? 2'b10 : 2'b01) : 2'b00;
    assign rdata = (r_state == RESP) ? r_rdata : '0;
    assign err   = (r_state == RESP) ? r_err : 1'b0;
    assign busy  = (r_state != IDLE);
    assign full  = w_full;
    assign empty = w_empty;
    assign count = r_count;

endmodule

// File: tb/tb_stack_arbiter.sv
// Randomized bench for stack_arbiter with a queue-based reference model and directed literal checks.
// Watermark output is also checked when STACK_ARBITER_WATERMARK_EN is defined.
module tb_stack_arbiter;

    localparam int WIDTH = 4;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic             clk;
    logic             rst;
    logic [1:0]       req;
    logic [1:0]       op;
    logic [WIDTH-1:0] wdata0;
    logic [WIDTH-1:0] wdata1;
    logic [1:0]       done;
    logic [WIDTH-1:0] rdata;
    logic             err;
    logic             busy;
    logic             full;
    logic             empty;
    logic [AW:0]      count;
`ifdef STACK_ARBITER_WATERMARK_EN
    logic             almost_full;
`endif

    stack_arbiter #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
`ifdef STACK_ARBITER_WATERMARK_EN
        ,
        .AF_LEVEL (14)
`endif
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .op     (op),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .done   (done),
        .rdata  (rdata),
        .err    (err),
        .busy   (busy),
        .full   (full),
        .empty  (empty),
`ifdef STACK_ARBITER_WATERMARK_EN
        .almost_full (almost_full),
`endif
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue as the stack plus the timing rules
    // (sample in a free cycle k, done at k+2, next sample no earlier than k+3).
    int   q[$];
    int   k         = 0;
    int   next_free = 0;
    int   m_cnt     = 0;
    bit   m_last    = 1'b1;
    bit   p_valid   = 1'b0;
    int   p_c, p_cnt, p_rdata;
    bit   p_err, p_push;
    logic [1:0] p_mask;

    always @(negedge clk) begin
        bit fin;
        bit w;
        int d;
        if (rst) begin
            chk("rst_count", int'(count), 0);
            chk("rst_empty", int'(empty), 1);
            chk("rst_full", int'(full), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_err", int'(err), 0);
            chk("rst_rdata", int'(rdata), 0);
`ifdef STACK_ARBITER_WATERMARK_EN
            chk("rst_af", int'(almost_full), 0);
`endif
            q.delete();
            m_last    = 1'b1;
            m_cnt     = 0;
            p_valid   = 1'b0;
            next_free = k + 1;
        end else begin
            fin = p_valid && (k == p_c + 2);
            if (fin) m_cnt = p_cnt;
            chk("done", int'(done), fin ? int'(p_mask) : 0);
            chk("err", int'(err), fin ? int'(p_err) : 0);
            if (!fin) chk("rdata_idle", int'(rdata), 0);
            else if (!p_push) chk("pop_rdata", int'(rdata), p_rdata);
            chk("busy", int'(busy), (p_valid && (k == p_c + 1 || fin)) ? 1 : 0);
            chk("count", int'(count), m_cnt);
            chk("full", int'(full), (m_cnt == DEPTH) ? 1 : 0);
            chk("empty", int'(empty), (m_cnt == 0) ? 1 : 0);
`ifdef STACK_ARBITER_WATERMARK_EN
            chk("almost_full", int'(almost_full), (m_cnt >= 14) ? 1 : 0);
`endif
            if (fin) p_valid = 1'b0;
            if (!p_valid && k >= next_free && req != 2'b00) begin
                w      = (req == 2'b11) ? !m_last : req[1];
                m_last = w;
                d      = w ? int'(wdata1) : int'(wdata0);
                p_push = op[w];
                p_rdata = 0;
                p_err   = 1'b0;
                if (p_push) begin
                    if (q.size() < DEPTH) q.push_back(d);
                    else p_err = 1'b1;
                end else begin
                    if (q.size() > 0) p_rdata = q.pop_back();
                    else p_err = 1'b1;
                end
                p_mask    = w ? 2'b10 : 2'b01;
                p_cnt     = q.size();
                p_c       = k;
                p_valid   = 1'b1;
                next_free = k + 3;
            end
        end
        k++;
    end

    task automatic do_op(input int who, input logic o, input logic [3:0] d,
                         output logic [1:0] m, output logic [3:0] rd,
                         output logic e, output int c);
        @(posedge clk); #1;
        req[who] = 1'b1;
        op[who]  = o;
        if (who == 0) wdata0 = d; else wdata1 = d;
        m = 2'b00; rd = '0; e = 1'b0; c = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done != 2'b00) begin
                m = done; rd = rdata; e = err; c = int'(count);
                break;
            end
        end
        if (m == 2'b00) chk("op_timeout", 0, 1);
        @(posedge clk); #1;
        req[who] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] m;
        logic [3:0] rd;
        logic       e;
        int         c;
        int         n_done, n_err, err_at;
        int         gnt[20];

        rst = 1'b1; req = 2'b00; op = 2'b00; wdata0 = '0; wdata1 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_empty", int'(empty), 1);
        chk("idle_busy", int'(busy), 0);

        // Push 0xA, push 0x5, then requester 1 pops 0x5.
        do_op(0, 1'b1, 4'hA, m, rd, e, c);
        chk("push1_done", int'(m), 1); chk("push1_count", c, 1);
        do_op(0, 1'b1, 4'h5, m, rd, e, c);
        chk("push2_done", int'(m), 1); chk("push2_count", c, 2);
        do_op(1, 1'b0, 4'h0, m, rd, e, c);
        chk("pop_done", int'(m), 2); chk("pop_rdata_lit", int'(rd), 5);
        chk("pop_err", int'(e), 0); chk("pop_count", c, 1);

        // Pop from empty.
        do_reset();
        do_op(0, 1'b0, 4'h0, m, rd, e, c);
        chk("pope_done", int'(m), 1); chk("pope_err", int'(e), 1);
        chk("pope_rdata", int'(rd), 0); chk("pope_count", c, 0);

        // Reset during EXEC of a second push.
        do_reset();
        do_op(0, 1'b1, 4'h3, m, rd, e, c);
        chk("p3_count", c, 1);
        req[0] = 1'b1; op[0] = 1'b1; wdata0 = 4'h7;
        @(posedge clk); #1;
        rst = 1'b1; req = 2'b00;
        #1;
        chk("async_count", int'(count), 0);
        chk("async_empty", int'(empty), 1);
        @(posedge clk); #1 rst = 1'b0;
        do_op(0, 1'b0, 4'h0, m, rd, e, c);
        chk("post_rst_pop_err", int'(e), 1);

        // Both requesters push at every opportunity.
        do_reset();
        n_done = 0; n_err = 0; err_at = -1;
        req = 2'b11; op = 2'b11; wdata0 = 4'h1; wdata1 = 4'h2;
        for (int cy = 0; cy < 51; cy++) begin
            @(negedge clk);
            if (done != 2'b00) begin
                if (n_done < 20) gnt[n_done] = int'(done[1]);
                if (err) begin n_err++; err_at = n_done; end
                n_done++;
            end
            @(posedge clk); #1;
            wdata0 = 4'($urandom); wdata1 = 4'($urandom);
        end
        req = 2'b00;
        chk("both_ndone", n_done, 17);
        for (int i = 0; i < 4; i++) chk("alt_grant", gnt[i], i % 2);
        chk("both_nerr", n_err, 1);
        chk("both_err_at", err_at, 16);
        @(negedge clk);
        chk("both_count", int'(count), 16);
        chk("both_full", int'(full), 1);

        // Random traffic, with occasional reset pulses.
        for (int cy = 0; cy < 1500; cy++) begin
            @(posedge clk); #1;
            rst    = ($urandom_range(0, 399) == 0);
            req    = 2'($urandom);
            for (int b = 0; b < 2; b++)
                op[b] = ($urandom_range(0, 99) < (((cy / 200) % 2 == 0) ? 25 : 75));
            wdata0 = 4'($urandom);
            wdata1 = 4'($urandom);
        end
        @(posedge clk); #1;
        rst = 1'b0; req = 2'b00;
        repeat (5) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
